wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
- Wishbone B4 pipelined slave (responder) backed by an internal word-addressed memory array.
- Sits on the far end of the external-memory master port: it accepts the requests that port issues and answers them in order, with a programmable number of wait states.
- Buffers up to FIFO_DEPTH outstanding requests and asserts stall when the buffer is full.
- Serves as both the simulation memory model and the FPGA on-chip RAM endpoint.

Parameters:
- ADDR_WIDTH, 10: word-index bits; memory holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2: cycles from request acceptance to ack with an empty queue; legal range 1..15.
- FIFO_DEPTH, 4: maximum outstanding requests, including the one in service; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- wb_adr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word; bits [1:0] and the upper bits are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1.
- wb_we_i  in  1  1=write, 0=read.
- wb_sel_i  in  4  byte-lane enables; bit k covers bits [8k+7:8k].
- wb_stb_i  in  1  request strobe.
- wb_cyc_i  in  1  bus cycle active.
- wb_ack_o  out  1  one-cycle completion pulse per accepted request.
- wb_stall_o  out  1  1 = request not accepted this cycle.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - wb_ack_o=0, wb_dat_o=0, wb_stall_o=0.
  - Queue emptied, service counter cleared.
  - Memory contents are not cleared.
  - Reset mid-operation discards all pending requests with no ack. A pending write is not performed unless it completed before the reset edge.
- Acceptance:
  - A request is accepted on an edge where wb_cyc_i & wb_stb_i & ~wb_stall_o.
  - {word index, dat, we, sel} is pushed into the queue.
  - No combinational path from the inputs to wb_stall_o. wb_stall_o = (count == FIFO_DEPTH), decoded from registered state only.
  - A pop in the same cycle does not clear stall early.
- Service (in order, head of queue):
  - States: IDLE and WAIT.
  - IDLE -> WAIT when the queue is non-empty; the counter loads LATENCY-1.
  - WAIT decrements each cycle. When the counter reaches 0, in that cycle:
    - wb_ack_o=1.
    - For a write, the selected bytes are written at the edge closing that cycle.
    - For a read, wb_dat_o = mem[word] (the registered output presents the value in the ack cycle).
    - The head is popped.
    - If more entries remain, the next request reloads LATENCY-1 immediately and stays in WAIT; otherwise the block returns to IDLE.
  - Timing: a request accepted at edge E with an empty queue is acked in the cycle beginning LATENCY edges after E.
  - Sustained throughput is one ack per LATENCY cycles. LATENCY=1 gives back-to-back acks every cycle.
- Reads:
  - wb_sel_i is ignored; the full word is returned.
  - wb_dat_o=0 whenever wb_ack_o=0.
- Ordering:
  - Strictly in order, so a read queued behind a write to the same word returns the new data.
- Push and pop together:
  - count unchanged.
  - With a non-full queue, a push into an empty queue while IDLE starts service the next cycle.
- Cycle abort:
  - When wb_cyc_i=0, the queue is flushed at that edge and the block returns to IDLE.
  - No further acks are issued for flushed requests; flushed writes are not performed.
  - An ack already asserted in the abort cycle is still driven, and its write still takes effect.
- Addresses:
  - Index wrap is implicit: any address aliases to adr[ADDR_WIDTH+1:2].
- Counters:
  - count is log2(FIFO_DEPTH)+1 bits; read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Test Plan:
- Single read:
  - Preload mem[0x10]=0xDEADBEEF, LATENCY=2.
  - Read adr 0x40 accepted at edge 0.
  - Required: wb_ack_o=1 only in cycle 2, wb_dat_o=0xDEADBEEF, wb_dat_o=0 in all other cycles.
- Byte-lane write:
  - mem[1]=0x11223344; write adr 0x4, dat 0xAABBCCDD, sel 4'b0101.
  - Then read adr 0x4.
  - Required: read returns 0x11BB33DD, with exactly 2 acks.
- Fill and stall, FIFO_DEPTH=4, LATENCY=3:
  - Issue 6 back-to-back reads.
  - Required: wb_stall_o=1 after the 4th acceptance, deasserting only the cycle after the first ack.
  - Required: 6 acks total, in issue order, 3 cycles apart.
- LATENCY=1 streaming:
  - 8 consecutive reads of words 0..7.
  - Required: acks on 8 consecutive cycles, wb_stall_o never 1, data in address order.
- Cycle abort:
  - 3 writes queued (words 5, 6, 7 = 0x1, 0x2, 0x3); deassert wb_cyc_i after the first ack.
  - Required: mem[5]=0x1, mem[6] and mem[7] unchanged, no further acks, wb_stall_o=0 next cycle.
- Reset mid-operation:
  - rst_i=0 for one edge with 2 reads queued.
  - Required: wb_ack_o=0 and wb_stall_o=0 from the following cycle, no acks for the discarded reads, memory contents intact.

Source files
------------

// File: rtl/wb_mem_responder_if.sv
// Wishbone B4 pipelined bus bundle between an
// external-memory master and wb_mem_responder.
interface wb_mem_responder_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i,
    output wb_dat_i,
    output wb_we_i,
    output wb_sel_i,
    output wb_stb_i,
    output wb_cyc_i,
    input  wb_dat_o,
    input  wb_ack_o,
    input  wb_stall_o
  );

  modport slave (
    input  wb_adr_i,
    input  wb_dat_i,
    input  wb_we_i,
    input  wb_sel_i,
    input  wb_stb_i,
    input  wb_cyc_i,
    output wb_dat_o,
    output wb_ack_o,
    output wb_stall_o
  );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined memory responder: queued,
// in-order requests answered after LATENCY cycles.
module wb_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_mem_responder_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] RELOAD = 4'(LATENCY - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           dat;
    logic                  we;
    logic [3:0]            sel;
  } req_t;

  logic [31:0]   mem [2**ADDR_WIDTH];
  req_t          fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  state_t        state;
  state_t        state_nxt;
  logic [31:0]   dat_q;
  logic [31:0]   dat_nxt;
  logic [31:0]   merged;
  logic          push;
  logic          ack;
  logic          full;
  req_t          head;
  req_t          next_head;
  req_t          nh;
  logic          unused;

  assign unused = ^{wb.wb_adr_i[31:ADDR_WIDTH+2],
                    wb.wb_adr_i[1:0]};

  assign head      = fifo[rd_ptr];
  assign next_head = fifo[rd_ptr + PW'(1)];
  assign full      = (count == FULL);
  assign push      = wb.wb_cyc_i & wb.wb_stb_i & ~full;
  assign ack       = (state == WAIT) && (cnt == '0);

  assign wb.wb_ack_o   = ack;
  assign wb.wb_stall_o = full;
  assign wb.wb_dat_o   = dat_q;

  // nh is the entry that will be in service next cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    nh        = head;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = WAIT;
          cnt_nxt   = RELOAD;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (count > CW'(1)) begin
          cnt_nxt = RELOAD;
          nh      = next_head;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!wb.wb_cyc_i) state_nxt = IDLE;
  end

  // forward a write acked now into a same-word read acked next
  always_comb begin
    merged = mem[nh.idx];
    if (ack && head.we && head.idx == nh.idx) begin
      for (int k = 0; k < 4; k++) begin
        if (head.sel[k])
          merged[8*k +: 8] = head.dat[8*k +: 8];
      end
    end
    dat_nxt = '0;
    if (state_nxt == WAIT && cnt_nxt == '0 && !nh.we)
      dat_nxt = merged;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      dat_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dat_q <= dat_nxt;
      if (!wb.wb_cyc_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (ack)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(ack);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo[wr_ptr] <= '{
        idx: wb.wb_adr_i[ADDR_WIDTH+1:2],
        dat: wb.wb_dat_i,
        we:  wb.wb_we_i,
        sel: wb.wb_sel_i
      };
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && ack && head.we) begin
      for (int k = 0; k < 4; k++) begin
        if (head.sel[k])
          mem[head.idx][8*k +: 8] <= head.dat[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder at LATENCY 1, 2
// and 3, checking ack timing, data, stall and aborts.
module tb_wb_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  int          act = 2;
  int          edge_n = 0;
  logic        ack_m;
  logic        stall_m;
  logic [31:0] dat_m;
  int          n_tests = 0;
  int          n_fail = 0;
  int          ack_edge[$];
  logic [31:0] ack_dat[$];
  int          dat_bad = 0;
  bit          stall_seen = 1'b0;
  bit          mon_en = 1'b0;
  logic        stall_hist [4096];

  wb_mem_responder_if w1 ();
  wb_mem_responder_if w2 ();
  wb_mem_responder_if w3 ();

  assign w1.wb_adr_i = adr;
  assign w1.wb_dat_i = dat;
  assign w1.wb_we_i  = we;
  assign w1.wb_sel_i = sel;
  assign w1.wb_stb_i = stb && act == 1;
  assign w1.wb_cyc_i = cyc && act == 1;
  assign w2.wb_adr_i = adr;
  assign w2.wb_dat_i = dat;
  assign w2.wb_we_i  = we;
  assign w2.wb_sel_i = sel;
  assign w2.wb_stb_i = stb && act == 2;
  assign w2.wb_cyc_i = cyc && act == 2;
  assign w3.wb_adr_i = adr;
  assign w3.wb_dat_i = dat;
  assign w3.wb_we_i  = we;
  assign w3.wb_sel_i = sel;
  assign w3.wb_stb_i = stb && act == 3;
  assign w3.wb_cyc_i = cyc && act == 3;

  wb_mem_responder #(.LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .wb(w1));
  wb_mem_responder #(.LATENCY(2)) u2 (
    .clk_i(clk), .rst_i(rst), .wb(w2));
  wb_mem_responder #(.LATENCY(3)) u3 (
    .clk_i(clk), .rst_i(rst), .wb(w3));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always_comb begin
    ack_m   = w2.wb_ack_o;
    stall_m = w2.wb_stall_o;
    dat_m   = w2.wb_dat_o;
    if (act == 1) begin
      ack_m   = w1.wb_ack_o;
      stall_m = w1.wb_stall_o;
      dat_m   = w1.wb_dat_o;
    end else if (act == 3) begin
      ack_m   = w3.wb_ack_o;
      stall_m = w3.wb_stall_o;
      dat_m   = w3.wb_dat_o;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_m === 1'b1) begin
        ack_edge.push_back(edge_n);
        ack_dat.push_back(dat_m);
      end
      if (ack_m !== 1'b1 && dat_m !== 32'd0) dat_bad++;
      if (stall_m === 1'b1) stall_seen = 1'b1;
      stall_hist[edge_n % 4096] = stall_m;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ack_edge.delete();
    ack_dat.delete();
    stall_seen = 1'b0;
  endtask

  function automatic int ae(input int i);
    return (i < ack_edge.size()) ? ack_edge[i] : -100;
  endfunction

  function automatic logic [31:0] ad(input int i);
    return (i < ack_dat.size()) ? ack_dat[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic        w,
                       input logic [3:0]  s);
    logic st;
    int   n;
    adr = a;
    dat = d;
    we  = w;
    sel = s;
    stb = 1'b1;
    cyc = 1'b1;
    n   = 0;
    do begin
      st = stall_m;
      tick();
      n++;
    end while (st !== 1'b0 && n < 50);
    if (st !== 1'b0) check("accept", {31'd0, st}, 32'd0);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    issue(32'(idx) << 2, d, 1'b1, 4'hF);
  endtask

  task automatic rd(input int idx);
    issue(32'(idx) << 2, 32'd0, 1'b0, 4'hF);
  endtask

  task automatic drain(input int n);
    int k;
    k   = 0;
    stb = 1'b0;
    while (ack_edge.size() < n && k < 60) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("drain", 32'(ack_edge.size()), 32'(n));
  endtask

  initial begin
    int e0;
    int acc[6];
    int k;

    repeat (3) tick();
    for (int a = 1; a <= 3; a++) begin
      act = a;
      #1;
      check("rst_ack", {31'd0, ack_m}, 32'd0);
      check("rst_stall", {31'd0, stall_m}, 32'd0);
      check("rst_dat", dat_m, 32'd0);
    end
    rst    = 1'b1;
    cyc    = 1'b1;
    act    = 2;
    mon_en = 1'b1;
    tick();

    // single read, LATENCY 2, sel ignored
    clear_log();
    wr(16, 32'hDEADBEEF);
    drain(1);
    clear_log();
    issue(32'h40, 32'd0, 1'b0, 4'h0);
    e0  = edge_n;
    stb = 1'b0;
    repeat (6) tick();
    check("rd_nack", 32'(ack_edge.size()), 32'd1);
    check("rd_lat", 32'(ae(0) - e0), 32'd2);
    check("rd_dat", ad(0), 32'hDEADBEEF);

    // byte-lane write then read
    clear_log();
    wr(1, 32'h11223344);
    drain(1);
    clear_log();
    issue(32'h4, 32'hAABBCCDD, 1'b1, 4'b0101);
    issue(32'h4, 32'd0, 1'b0, 4'hF);
    drain(2);
    check("bl_dat", ad(1), 32'h11BB33DD);

    // fill and stall, LATENCY 3
    act = 3;
    tick();
    clear_log();
    for (int i = 0; i < 6; i++) wr(i, 32'h300 + 32'(i));
    drain(6);
    clear_log();
    for (int i = 0; i < 6; i++) begin
      rd(i);
      acc[i] = edge_n;
      if (i == 3)
        check("stall_full", {31'd0, stall_m}, 32'd1);
    end
    drain(6);
    check("fill_lat", 32'(ae(0) - acc[0]), 32'd3);
    check("stall_ack",
          {31'd0, stall_hist[ae(0) % 4096]}, 32'd1);
    check("stall_rel",
          {31'd0, stall_hist[(ae(0) + 1) % 4096]}, 32'd0);
    for (int i = 0; i < 6; i++)
      check("fill_dat", ad(i), 32'h300 + 32'(i));
    for (int i = 1; i < 6; i++)
      check("fill_gap", 32'(ae(i) - ae(i - 1)), 32'd3);

    // LATENCY 1 streaming
    act = 1;
    tick();
    clear_log();
    for (int i = 0; i < 8; i++) wr(i, 32'h200 + 32'(i));
    drain(8);
    clear_log();
    for (int i = 0; i < 8; i++) rd(i);
    drain(8);
    check("str_stall", {31'd0, stall_seen}, 32'd0);
    for (int i = 0; i < 8; i++)
      check("str_dat", ad(i), 32'h200 + 32'(i));
    for (int i = 1; i < 8; i++)
      check("str_gap", 32'(ae(i) - ae(i - 1)), 32'd1);

    // same-word write then read, back to back
    clear_log();
    wr(9, 32'hCAFEF00D);
    rd(9);
    drain(2);
    check("fwd_dat", ad(1), 32'hCAFEF00D);
    check("fwd_gap", 32'(ae(1) - ae(0)), 32'd1);

    // cycle abort after first ack
    act = 2;
    tick();
    clear_log();
    wr(5, 32'hA5);
    wr(6, 32'hA6);
    wr(7, 32'hA7);
    drain(3);
    clear_log();
    wr(5, 32'h1);
    wr(6, 32'h2);
    wr(7, 32'h3);
    k = 0;
    while (ack_m !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    cyc = 1'b0;
    stb = 1'b0;
    tick();
    check("ab_stall", {31'd0, stall_m}, 32'd0);
    check("ab_ack", {31'd0, ack_m}, 32'd0);
    repeat (6) tick();
    check("ab_nack", 32'(ack_edge.size()), 32'd1);
    cyc = 1'b1;
    clear_log();
    rd(5);
    rd(6);
    rd(7);
    drain(3);
    check("ab_m5", ad(0), 32'h1);
    check("ab_m6", ad(1), 32'hA6);
    check("ab_m7", ad(2), 32'hA7);

    // reset with requests pending
    clear_log();
    wr(20, 32'h55);
    wr(21, 32'h66);
    wr(22, 32'h88);
    drain(3);
    clear_log();
    rd(20);
    wr(22, 32'h77);
    rst = 1'b0;
    stb = 1'b0;
    tick();
    rst = 1'b1;
    check("rs_ack", {31'd0, ack_m}, 32'd0);
    check("rs_stall", {31'd0, stall_m}, 32'd0);
    check("rs_dat", dat_m, 32'd0);
    repeat (6) tick();
    check("rs_nack", 32'(ack_edge.size()), 32'd0);
    clear_log();
    rd(20);
    rd(21);
    rd(22);
    drain(3);
    check("rs_m20", ad(0), 32'h55);
    check("rs_m21", ad(1), 32'h66);
    check("rs_m22", ad(2), 32'h88);

    check("dat_idle", 32'(dat_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
